br_fifo_static_multi_push_ctrl: RTL and testbench

Push-side controller for a set of logical FIFOs that share one single-write-port RAM, statically partitioned into equal per-FIFO regions. Arbitrates among the push requesters each cycle and issues at most one RAM write. Maintains a write pointer, slot count and full flag per FIFO. Sits between the per-FIFO push interfaces and the shared RAM; each FIFO's pop controller reports dequeues back through `pop_beat`.

---
 rtl/br_fifo_static_multi_push_ctrl.sv | 162 ++++++++++++++++
 tb/tb_br_fifo_static_multi_push_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_fifo_static_multi_push_ctrl.sv
// Push-side controller for logical FIFOs sharing one statically partitioned RAM.
// Define BR_FIFO_MULTI_PUSH_FIXED_PRIO_EN for fixed (lowest-index) priority.
module br_fifo_static_multi_push_ctrl #(
  parameter int NumFifos = 2,
  parameter int Depth = 4,
  parameter int Width = 1,
  localparam int RamDepth = NumFifos * Depth,
  localparam int AddrWidth = (RamDepth > 1) ? $clog2(RamDepth) : 1,
  localparam int CountWidth = $clog2(Depth + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumFifos-1:0]            push_valid,
  input  logic [NumFifos*Width-1:0]      push_data,
  output logic [NumFifos-1:0]            push_ready,
  output logic [NumFifos-1:0]            full,
  output logic [NumFifos*CountWidth-1:0] slots,
  output logic                           ram_wr_valid,
  output logic [AddrWidth-1:0]           ram_wr_addr,
  output logic [Width-1:0]               ram_wr_data,
  output logic [NumFifos-1:0]            push_beat,
  input  logic [NumFifos-1:0]            pop_beat
);

  localparam int IdWidth = $clog2(NumFifos);
  localparam int PtrWidth = $clog2(Depth);

  logic [NumFifos-1:0]   eligible;
  logic [NumFifos-1:0]   grant;
  logic [IdWidth-1:0]    gidx;
  logic                  found;
  logic [PtrWidth-1:0]   wr_ptr [NumFifos];
  logic [CountWidth-1:0] slots_q [NumFifos];
  logic [CountWidth-1:0] slots_nxt [NumFifos];

  // Requests are masked during reset so nothing is granted or written.
  assign eligible = push_valid & ~full & {NumFifos{~rst}};

`ifndef BR_FIFO_MULTI_PUSH_FIXED_PRIO_EN
  logic [IdWidth-1:0] prio;

  // Round-robin: first eligible index at or after prio, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx = '0;
    grant = '0;
    for (int k = 0; k < NumFifos; k++) begin
      idx = (int'(prio) + k) % NumFifos;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        gidx = IdWidth'(idx);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  // Priority moves just past the winner; holds when idle.
  always_ff @(posedge clk) begin
    if (rst) prio <= '0;
    else if (found)
      prio <= (int'(gidx) == NumFifos - 1) ? '0 : gidx + IdWidth'(1);
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    found = 1'b0;
    gidx = '0;
    grant = '0;
    for (int k = 0; k < NumFifos; k++) begin
      if (!found && eligible[k]) begin
        found = 1'b1;
        gidx = IdWidth'(k);
      end
    end
    if (found) grant[gidx] = 1'b1;
  end
`endif

  assign push_ready = grant;
  assign push_beat = push_valid & push_ready;
  assign ram_wr_valid = |push_beat;

  // Address is the winner's region base plus its write pointer.
  always_comb begin
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (found) begin
      ram_wr_addr = AddrWidth'(int'(gidx) * Depth + int'(wr_ptr[gidx]));
      ram_wr_data = push_data[int'(gidx)*Width +: Width];
    end
  end

  // Next free-slot count per FIFO from push/pop beats.
  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      slots_nxt[i] = slots_q[i];
      if (push_beat[i] && !pop_beat[i])
        slots_nxt[i] = slots_q[i] - CountWidth'(1);
      else if (!push_beat[i] && pop_beat[i])
        slots_nxt[i] = slots_q[i] + CountWidth'(1);
    end
  end

  // Per-FIFO write pointer, slot count and full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumFifos; i++) begin
        wr_ptr[i] <= '0;
        slots_q[i] <= CountWidth'(Depth);
        full[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NumFifos; i++) begin
        if (push_beat[i])
          wr_ptr[i] <= (wr_ptr[i] == PtrWidth'(Depth - 1)) ?
                       '0 : wr_ptr[i] + PtrWidth'(1);
        if (push_beat[i] || pop_beat[i]) begin
          slots_q[i] <= slots_nxt[i];
          full[i] <= (slots_nxt[i] == '0);
        end
      end
    end
  end

  for (genvar i = 0; i < NumFifos; i++) begin : g_slots
    assign slots[i*CountWidth +: CountWidth] = slots_q[i];
  end

`ifndef SYNTHESIS
  int wait_q [NumFifos];

  // Cycles each eligible requester has gone ungranted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumFifos; i++) begin
      if (rst) wait_q[i] <= 0;
      else wait_q[i] <= (eligible[i] && !grant[i]) ? wait_q[i] + 1 : 0;
    end
  end

  for (genvar i = 0; i < NumFifos; i++) begin : g_chk
    a_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop_beat[i] && slots_q[i] == CountWidth'(Depth)));
    a_stable: assert property (@(posedge clk) disable iff (rst)
      (!rst && push_valid[i] && !push_ready[i] && !full[i]) |=>
      (push_valid[i] && $stable(push_data[i*Width +: Width])));
`ifndef BR_FIFO_MULTI_PUSH_FIXED_PRIO_EN
    a_fair: assert property (@(posedge clk) disable iff (rst)
      wait_q[i] < NumFifos);
`else
    c_starve: cover property (@(posedge clk) disable iff (rst)
      wait_q[i] >= NumFifos);
`endif
  end

  final begin
    for (int i = 0; i < NumFifos; i++)
      a_end_empty: assert (slots_q[i] == CountWidth'(Depth));
  end
`endif

endmodule

// File: tb/tb_br_fifo_static_multi_push_ctrl.sv
// Directed bench for br_fifo_static_multi_push_ctrl.
// RAM writes are checked against a scoreboard of expected address/data.
module tb_br_fifo_static_multi_push_ctrl;
  localparam int NF = 2;
  localparam int D = 4;
  localparam int W = 8;
  localparam int CW = 3;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NF-1:0] push_valid;
  logic [NF*W-1:0] push_data;
  logic [NF-1:0] push_ready;
  logic [NF-1:0] full;
  logic [NF*CW-1:0] slots;
  logic ram_wr_valid;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0] ram_wr_data;
  logic [NF-1:0] push_beat;
  logic [NF-1:0] pop_beat;

  br_fifo_static_multi_push_ctrl #(
    .NumFifos(NF), .Depth(D), .Width(W)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .full(full), .slots(slots),
    .ram_wr_valid(ram_wr_valid), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .push_beat(push_beat),
    .pop_beat(pop_beat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  wr_t exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expw(int a, int d);
    wr_t w;
    w.a = AW'(a);
    w.d = W'(d);
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_valid = '0;
    pop_beat = '0;
    tick();
    rst = 1'b0;
  endtask

  // Every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (ram_wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_wr: observed addr %0h data %0h expected none",
               ram_wr_addr, ram_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_wr_addr), 32'(e.a));
        chk("wr_data", 32'(ram_wr_data), 32'(e.d));
      end
    end
  end

  int n0, n1, g;

  initial begin
    rst = 1'b1;
    push_valid = '0;
    push_data = '0;
    pop_beat = '0;
    tick();
    tick();
    chk("rst_slots", 32'(slots), 32'({3'd4, 3'd4}));
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(push_ready), 0);
    chk("rst_wr_valid", 32'(ram_wr_valid), 0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 0);
    chk("rst_wr_data", 32'(ram_wr_data), 0);
    rst = 1'b0;

    // Single push on port 1.
    push_valid = 2'b10;
    push_data = {8'hA5, 8'h00};
    #1;
    chk("s1_ready", 32'(push_ready), 2);
    chk("s1_beat", 32'(push_beat), 2);
    chk("s1_wr_valid", 32'(ram_wr_valid), 1);
    chk("s1_addr", 32'(ram_wr_addr), 4);
    expw(4, 'hA5);
    tick();
    push_valid = '0;
    chk("s1_slots1", 32'(slots[5:3]), 3);
    chk("s1_slots0", 32'(slots[2:0]), 4);

    // Both ports continuously valid: round-robin until both full.
    do_reset();
    n0 = 0;
    n1 = 0;
    push_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      g = c % 2;
      push_data = {8'(8'h20 + n1), 8'(8'h10 + n0)};
      #1;
      chk("rr_ready", 32'(push_ready), (g == 1) ? 2 : 1);
      if (g == 1) expw(4 + n1, 'h20 + n1);
      else expw(n0, 'h10 + n0);
      tick();
      if (g == 1) n1++;
      else n0++;
    end
    #1;
    chk("rr_full", 32'(full), 3);
    chk("rr_ready_full", 32'(push_ready), 0);
    chk("rr_slots", 32'(slots), 0);

    // Pop releases FIFO0 backpressure one cycle later.
    pop_beat = 2'b01;
    #1;
    chk("bp_ready_while_full", 32'(push_ready), 0);
    tick();
    pop_beat = '0;
    chk("bp_full", 32'(full), 2);
    chk("bp_slots0", 32'(slots[2:0]), 1);
    chk("bp_ready", 32'(push_ready), 1);
    expw(0, 'h14);
    tick();
    push_valid = '0;
    chk("bp_refull", 32'(full), 3);
    pop_beat = 2'b11;
    repeat (4) tick();
    pop_beat = '0;
    chk("bp_drain", 32'(slots), 32'({3'd4, 3'd4}));
    chk("bp_drain_full", 32'(full), 0);

    // Wrap-around of FIFO0 write pointer.
    do_reset();
    push_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      push_data = {8'h00, 8'(8'h30 + k)};
      #1;
      chk("wr_ready", 32'(push_ready), 1);
      expw(k, 'h30 + k);
      tick();
    end
    push_valid = '0;
    chk("wr_full0", 32'(full), 1);
    chk("wr_slots0_0", 32'(slots[2:0]), 0);
    pop_beat = 2'b01;
    repeat (4) tick();
    pop_beat = '0;
    chk("wr_slots0_4", 32'(slots[2:0]), 4);
    push_valid = 2'b01;
    push_data = {8'h00, 8'h40};
    #1;
    chk("wrap_addr", 32'(ram_wr_addr), 0);
    expw(0, 'h40);
    tick();
    push_valid = '0;
    chk("wrap_slots0", 32'(slots[2:0]), 3);
    push_valid = 2'b01;
    push_data = {8'h00, 8'h41};
    expw(1, 'h41);
    tick();
    push_valid = '0;
    chk("pp_pre_slots0", 32'(slots[2:0]), 2);

    // Simultaneous push and pop leave the count unchanged.
    push_valid = 2'b01;
    pop_beat = 2'b01;
    push_data = {8'h00, 8'h42};
    #1;
    chk("pp_ready", 32'(push_ready), 1);
    expw(2, 'h42);
    tick();
    push_valid = '0;
    pop_beat = '0;
    chk("pp_slots0", 32'(slots[2:0]), 2);
    chk("pp_full", 32'(full), 0);
    pop_beat = 2'b01;
    repeat (2) tick();
    pop_beat = '0;

    // Reset mid-operation with requests pending.
    do_reset();
    push_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      push_data = {8'h00, 8'(8'h50 + k)};
      expw(k, 'h50 + k);
      tick();
    end
    chk("mr_slots0", 32'(slots[2:0]), 1);
    rst = 1'b1;
    push_valid = 2'b11;
    push_data = {8'h66, 8'h55};
    #1;
    chk("mr_ready_in_rst", 32'(push_ready), 0);
    chk("mr_wr_valid_in_rst", 32'(ram_wr_valid), 0);
    tick();
    chk("mr_slots", 32'(slots), 32'({3'd4, 3'd4}));
    chk("mr_full", 32'(full), 0);
    rst = 1'b0;
    push_valid = 2'b01;
    push_data = {8'h00, 8'h77};
    #1;
    chk("mr_ready", 32'(push_ready), 1);
    chk("mr_addr", 32'(ram_wr_addr), 0);
    expw(0, 'h77);
    tick();
    push_valid = '0;
    pop_beat = 2'b01;
    tick();
    pop_beat = '0;

    #1;
    chk("end_slots", 32'(slots), 32'({3'd4, 3'd4}));
    chk("end_queue", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
